// File: rtl/led_spinner_core.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : led_spinner_core
// Description : Clocked LED animation engine. A prescaler produces a step
//               every period+1 active cycles. Each step advances a position
//               or fill level in one of four modes: spin, bounce, fill and
//               blank. The LED bank shows the pattern of that state.
//
// Ports       : clk     - system clock
//               rst_n   - asynchronous active-low reset
//               ena     - global enable; 0 freezes all state
//               mode    - 00 spin, 01 bounce, 10 fill, 11 blank
//               dir     - 0 toward higher index, 1 toward lower (spin, fill)
//               pause   - freezes prescaler and pattern
//               period  - step every period+1 active cycles
//               leds    - registered LED pattern
//               pos     - position (spin/bounce) or fill level (fill)
//               step    - one-cycle pulse, coincides with the pos update
//
// Revision    : 1.0 - initial release
// ============================================================================
module led_spinner_core #(
    parameter int N_LEDS   = 8,
    parameter int PERIOD_W = 16,
    parameter int POS_W    = $clog2(N_LEDS + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ena,
    input  logic [1:0]          mode,
    input  logic                dir,
    input  logic                pause,
    input  logic [PERIOD_W-1:0] period,
    output logic [N_LEDS-1:0]   leds,
    output logic [POS_W-1:0]    pos,
    output logic                step
);

    localparam logic [1:0] c_MODE_SPIN   = 2'b00;
    localparam logic [1:0] c_MODE_BOUNCE = 2'b01;
    localparam logic [1:0] c_MODE_FILL   = 2'b10;

    // Bounce travel direction state
    localparam logic [0:0] c_BDIR_UP   = 1'b0;
    localparam logic [0:0] c_BDIR_DOWN = 1'b1;

    localparam logic [POS_W-1:0] c_POS_ONE      = POS_W'(1);
    localparam logic [POS_W-1:0] c_POS_LAST     = POS_W'(N_LEDS - 1);
    localparam logic [POS_W-1:0] c_POS_PRE_LAST = POS_W'(N_LEDS - 2);
    localparam logic [POS_W-1:0] c_POS_FULL     = POS_W'(N_LEDS);

    logic [PERIOD_W-1:0] r_cnt;
    logic [POS_W-1:0]    r_pos;
    logic [0:0]          r_bdir;
    logic [1:0]          r_mode_q;
    logic [N_LEDS-1:0]   r_leds;
    logic                r_step;

    logic                w_active;
    logic                w_restart;
    logic                w_wrap;
    logic                w_fire;
    logic [PERIOD_W-1:0] w_cnt_nxt;
    logic [POS_W-1:0]    w_pos_nxt;
    logic [0:0]          w_bdir_nxt;
    logic [N_LEDS-1:0]   w_onehot;
    logic [N_LEDS-1:0]   w_fill_lo;
    logic [N_LEDS-1:0]   w_fill_hi;
    logic [N_LEDS-1:0]   w_pattern;

    assign w_active  = ena & ~pause;
    // A mode change restarts the animation even while paused
    assign w_restart = ena & (mode != r_mode_q);
    // >= so that lowering period below the running count fires at once
    assign w_wrap    = (r_cnt >= period);

    // Per-bit pattern terms: one-hot at pos, low `level` bits, high `level` bits
    for (genvar gi = 0; gi < N_LEDS; gi++) begin : g_pattern
        assign w_onehot[gi]  = (r_pos == POS_W'(gi));
        assign w_fill_lo[gi] = (POS_W'(gi) < r_pos);
        assign w_fill_hi[gi] = (POS_W'(N_LEDS - 1 - gi) < r_pos);
    end

    // Fill orientation follows the live dir input so a dir change mirrors
    // the bar on the very next LED update.
    always_comb begin
        w_pattern = '0;
        case (r_mode_q)
            c_MODE_SPIN,
            c_MODE_BOUNCE: w_pattern = w_onehot;
            c_MODE_FILL:   w_pattern = dir ? w_fill_hi : w_fill_lo;
            default:       w_pattern = '0;
        endcase
    end

    always_comb begin
        w_cnt_nxt  = r_cnt;
        w_pos_nxt  = r_pos;
        w_bdir_nxt = r_bdir;
        w_fire     = 1'b0;
        if (w_restart) begin
            w_cnt_nxt  = '0;
            w_pos_nxt  = '0;
            w_bdir_nxt = c_BDIR_UP;
        end else if (w_active) begin
            if (w_wrap) begin
                w_cnt_nxt = '0;
                w_fire    = 1'b1;
            end else begin
                w_cnt_nxt = r_cnt + PERIOD_W'(1);
            end
            if (w_fire) begin
                case (r_mode_q)
                    c_MODE_SPIN: begin
                        if (dir) begin
                            w_pos_nxt = (r_pos == '0) ? c_POS_LAST : r_pos - c_POS_ONE;
                        end else begin
                            w_pos_nxt = (r_pos == c_POS_LAST) ? '0 : r_pos + c_POS_ONE;
                        end
                    end
                    c_MODE_BOUNCE: begin
                        // Turn at the ends so each endpoint is shown for one step only
                        if (r_bdir == c_BDIR_UP) begin
                            if (r_pos == c_POS_LAST) begin
                                w_bdir_nxt = c_BDIR_DOWN;
                                w_pos_nxt  = c_POS_PRE_LAST;
                            end else begin
                                w_pos_nxt = r_pos + c_POS_ONE;
                            end
                        end else begin
                            if (r_pos == '0) begin
                                w_bdir_nxt = c_BDIR_UP;
                                w_pos_nxt  = c_POS_ONE;
                            end else begin
                                w_pos_nxt = r_pos - c_POS_ONE;
                            end
                        end
                    end
                    c_MODE_FILL: begin
                        w_pos_nxt = (r_pos == c_POS_FULL) ? '0 : r_pos + c_POS_ONE;
                    end
                    default: w_pos_nxt = r_pos;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_pos    <= '0;
            r_bdir   <= c_BDIR_UP;
            r_mode_q <= c_MODE_SPIN;
            r_leds   <= '0;
            r_step   <= 1'b0;
        end else begin
            r_cnt  <= w_cnt_nxt;
            r_pos  <= w_pos_nxt;
            r_bdir <= w_bdir_nxt;
            r_step <= w_fire;
            if (ena) begin
                r_mode_q <= mode;
            end
            // LEDs show the state as it stood before this edge
            if (w_active) begin
                r_leds <= w_pattern;
            end
        end
    end

    assign leds = r_leds;
    assign pos  = r_pos;
    assign step = r_step;

endmodule
`default_nettype wire

// File: tb/tb_led_spinner_core.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_led_spinner_core
// Description : Self-checking bench for led_spinner_core. Stimulus applies
//               inputs on the falling edge and pushes the expected outputs
//               of a behavioural model into a queue; a monitor pops and
//               compares after every rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_led_spinner_core;

    localparam int N  = 8;
    localparam int PW = 16;
    localparam int PS = $clog2(N + 1);

    logic          clk    = 1'b0;
    logic          rst_n  = 1'b0;
    logic          ena    = 1'b0;
    logic [1:0]    mode   = 2'b00;
    logic          dir    = 1'b0;
    logic          pause  = 1'b0;
    logic [PW-1:0] period = '0;
    logic [N-1:0]  leds;
    logic [PS-1:0] pos;
    logic          step;

    always #5 clk = ~clk;

    led_spinner_core #(
        .N_LEDS   (N),
        .PERIOD_W (PW)
    ) u_dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .ena    (ena),
        .mode   (mode),
        .dir    (dir),
        .pause  (pause),
        .period (period),
        .leds   (leds),
        .pos    (pos),
        .step   (step)
    );

    typedef struct packed {
        logic [N-1:0]  leds;
        logic [PS-1:0] pos;
        logic          step;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    // Behavioural model: bounce is a phase around a 2N-2 long sweep
    int           m_cnt, m_pos, m_phase, m_mode;
    logic [N-1:0] m_leds;
    logic         m_step;

    task automatic model_reset();
        m_cnt = 0; m_pos = 0; m_phase = 0; m_mode = 0;
        m_leds = '0; m_step = 1'b0;
    endtask

    function automatic logic [N-1:0] pattern(int md, int lvl, logic d);
        logic [63:0] ones;
        ones = (64'd1 << lvl) - 64'd1;
        case (md)
            0, 1:    pattern = N'(64'd1 << lvl);
            2:       pattern = d ? N'(ones << (N - lvl)) : N'(ones);
            default: pattern = '0;
        endcase
    endfunction

    task automatic check(input string name, input exp_t act, input exp_t exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got leds=%h pos=%0d step=%b, expected leds=%h pos=%0d step=%b",
                     name, $time, act.leds, act.pos, act.step, exp.leds, exp.pos, exp.step);
        end
    endtask

    // Called on a falling edge: drive inputs, advance the model, wait one cycle
    task automatic cyc(input logic e, input logic p, input logic [1:0] md,
                       input logic d, input int per);
        logic [N-1:0] pat;
        ena = e; pause = p; mode = md; dir = d; period = PW'(per);
        m_step = 1'b0;
        if (e) begin
            pat = pattern(m_mode, m_pos, d);
            if (int'(md) != m_mode) begin
                m_cnt = 0; m_pos = 0; m_phase = 0;
            end else if (!p) begin
                if (m_cnt >= per) begin
                    m_cnt  = 0;
                    m_step = 1'b1;
                    case (m_mode)
                        0: m_pos = d ? (m_pos + N - 1) % N : (m_pos + 1) % N;
                        1: begin
                            m_phase = (m_phase + 1) % (2 * N - 2);
                            m_pos   = (m_phase < N) ? m_phase : 2 * N - 2 - m_phase;
                        end
                        2: m_pos = (m_pos + 1) % (N + 1);
                        default: ;
                    endcase
                end else begin
                    m_cnt++;
                end
            end
            if (!p) m_leds = pat;
            m_mode = int'(md);
        end
        q.push_back({m_leds, PS'(m_pos), m_step});
        @(negedge clk);
    endtask

    // Asserted between edges so the reset must act without a clock
    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1 check("async_reset", {leds, pos, step}, '0);
        model_reset();
        ena = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (q.size() != 0) begin
                exp_t e;
                e = q.pop_front();
                check("outputs", {leds, pos, step}, e);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        logic [1:0] cur_mode;
        logic       cur_dir;
        model_reset();
        repeat (2) @(negedge clk);
        check("reset_state", {leds, pos, step}, '0);
        rst_n = 1'b1;

        repeat (40) cyc(1, 0, 2'd0, 0, 3);
        repeat (20) cyc(1, 0, 2'd0, 1, 0);
        repeat (40) cyc(1, 0, 2'd1, 1'($urandom_range(0, 1)), 0);
        repeat (7)  cyc(1, 0, 2'd2, 0, 1);
        repeat (20) cyc(1, 0, 2'd2, 1, 1);
        // Spin to pos 5, pause, switch mode during the pause, release
        repeat (6)  cyc(1, 0, 2'd0, 0, 0);
        repeat (5)  cyc(1, 1, 2'd0, 0, 0);
        repeat (5)  cyc(1, 1, 2'd2, 0, 3);
        repeat (12) cyc(1, 0, 2'd2, 0, 3);
        // Lower the period mid-count
        repeat (55) cyc(1, 0, 2'd0, 0, 100);
        repeat (30) cyc(1, 0, 2'd0, 0, 10);
        repeat (3)  cyc(1, 0, 2'd3, 0, 1);
        repeat (4)  cyc(1, 0, 2'd0, 0, 0);
        do_reset();

        cur_mode = 2'd0;
        cur_dir  = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 39) == 0) cur_mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0)  cur_dir  = ~cur_dir;
            if ($urandom_range(0, 499) == 0) begin
                do_reset();
            end else begin
                cyc(1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 7) == 0),
                    cur_mode, cur_dir, int'($urandom_range(0, 4)));
            end
        end

        ena = 1'b0;
        repeat (2) @(negedge clk);
        n_vec++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
